fft4_in_loader: RTL and testbench
=================================

# fft4_in_loader

Input framing stage for the 4-point radix-2 FFT core. It accepts a serial stream of complex samples over a valid/ready handshake and groups them into 4-sample frames. Each frame is presented to the core's four parallel complex inputs in bit-reversed butterfly order. Two frame buffers (ping-pong) let the next frame be collected while the current one waits for the core.

## Interface
- DATA_W, 16, width of each real/imag component; equals the core's input bus width.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample this cycle.
- s_first  in  1  marks sample 0 of a frame; qualified by s_valid & s_ready.
- s_r, s_i  in  DATA_W each  signed sample, real and imaginary.
- m_valid  out  1  complete frame presented on the out_* ports.
- m_ready  in  1  core side consumes the frame.
- out_1_1_r/i, out_1_2_r/i, out_2_1_r/i, out_2_2_r/i  out  DATA_W each  signed frame samples, mapped to the core's in_1_1 … in_2_2.
- err_sync  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- Storage: two buffers, BUF0 and BUF1. Each holds 4 complex words plus a full flag.
- Pointers: wr_sel and rd_sel select the write and read buffer. widx (2 bits) is the write index.
- Accept condition: a sample is accepted when s_valid & s_ready.
  - The sample is written to buffer[wr_sel] at slot widx.
  - widx then increments.
- Frame complete: when widx==3 and a sample is accepted:
  - full[wr_sel] is set,
  - wr_sel toggles,
  - widx wraps to 0.
- s_ready = ~full[wr_sel] & ~rst. This is combinational from registered state only; there is no path from m_ready.
- m_valid = full[rd_sel].
- Consume: on m_valid & m_ready, full[rd_sel] clears and rd_sel toggles.
- Output mapping from buffer[rd_sel], with slot n = sample x[n]:
  - out_1_1 = x0
  - out_1_2 = x2
  - out_2_1 = x1
  - out_2_2 = x3
  - This places butterfly pairs (x0,x2) and (x1,x3) on the core's pair ports.
- Output hold: out_* are a mux of registers. They stay stable while m_valid & ~m_ready.
- Resync on s_first:
  - If an accepted sample has s_first=1 and widx≠0, the partial frame is dropped.
  - The sample is written to slot 0 and widx becomes 1.
  - err_sync pulses for one cycle.
  - s_first with widx==0 is normal.
  - s_first=0 with widx==0 is accepted as sample 0, with no error.
- Arithmetic: none. Samples pass through bit-exact, with no sign extension.

## Timing
- Reset values (cycle after rst sampled high): widx=0, wr_sel=0, rd_sel=0, both full=0, buffer contents 0.
- Outputs during and after reset:
  - m_valid=0, all out_*=0, err_sync=0.
  - s_ready=0 while rst=1, and 1 in the first cycle after rst drops.
- Reset mid-frame discards all stored and partial frames. No m_valid follows for pre-reset data.
- Latency: 4th sample accepted at edge t → m_valid=1 and frame data valid from t to the next edge. That is, one cycle after the handshake cycle.
- Throughput: 1 sample/cycle sustained while m_ready is held high every cycle m_valid is set.
- Both buffers full → s_ready=0.
  - When a consume frees a buffer at edge t, s_ready rises after t. It is never asserted in the same cycle as the m_ready that frees it.
- Simultaneous frame complete (into wr_sel) and consume (from rd_sel≠wr_sel) in one cycle: both take effect. Flags are updated independently per buffer.
- err_sync is registered and high exactly one cycle after the offending handshake.

## Test plan
- Reset, then samples (1,−1),(2,−2),(3,−3),(4,−4) on consecutive cycles with m_ready=1:
  - m_valid is high one cycle after the 4th handshake.
  - out_1_1=(1,−1), out_1_2=(3,−3), out_2_1=(2,−2), out_2_2=(4,−4).
  - s_ready stays 1 throughout.
- Back-pressure: m_ready=0 while streaming 12 samples 1..12:
  - 8 samples are accepted, then s_ready=0.
  - Frame {1,3,2,4} (out_1_1,out_1_2,out_2_1,out_2_2) holds stable.
  - Raising m_ready for 1 cycle → next frame shows {5,7,6,8}, and s_ready returns 1 a cycle later.
- Continuous stream of 16 samples with m_ready=1:
  - 4 frames, each m_valid for one cycle, spaced 4 cycles apart.
  - No s_ready drop.
- Resync: send 10, 11, then 20 with s_first=1, then 21, 22, 23:
  - err_sync pulses once.
  - Frame is out_1_1=20, out_1_2=22, out_2_1=21, out_2_2=23.
- Reset mid-operation: 1 frame held plus 2 samples pending, then assert rst for 1 cycle:
  - m_valid=0 and out_*=0.
  - The next 4 samples 100..103 produce frame {100,102,101,103}.
- Full-width values: real 0x7FFF and imaginary 0x8000 in every slot pass unchanged, with no sign corruption.

Source files
------------

// File: rtl/fft4_in_loader_if.sv
// fft4_in_loader_if
//   Bundles the sample stream and the frame output of the 4-point FFT input
//   loader.
//   Handshakes: a transfer happens on a rising clock edge where valid and
//   ready are both high. A source holds valid and its payload stable until
//   that transfer. Ready may depend only on the receiver's registered state.
//   - s_*   : serial complex samples into the loader (s_first marks sample 0).
//   - m_*   : a complete 4-sample frame, presented on out_* to the FFT core.
//   - err_sync : one-cycle pulse when a partial frame is dropped on resync.
//   Modports:
//   - slave  : the loader's view of the bus.
//   - master : the environment's view (sample source plus frame consumer).
interface fft4_in_loader_if #(
  parameter int DATA_W = 16
);
  logic              s_valid;
  logic              s_ready;
  logic              s_first;
  logic [DATA_W-1:0] s_r;
  logic [DATA_W-1:0] s_i;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] out_1_1_r;
  logic [DATA_W-1:0] out_1_1_i;
  logic [DATA_W-1:0] out_1_2_r;
  logic [DATA_W-1:0] out_1_2_i;
  logic [DATA_W-1:0] out_2_1_r;
  logic [DATA_W-1:0] out_2_1_i;
  logic [DATA_W-1:0] out_2_2_r;
  logic [DATA_W-1:0] out_2_2_i;
  logic              err_sync;

  modport slave (
    input  s_valid, s_first, s_r, s_i, m_ready,
    output s_ready, m_valid, err_sync,
    output out_1_1_r, out_1_1_i, out_1_2_r, out_1_2_i,
    output out_2_1_r, out_2_1_i, out_2_2_r, out_2_2_i
  );

  modport master (
    output s_valid, s_first, s_r, s_i, m_ready,
    input  s_ready, m_valid, err_sync,
    input  out_1_1_r, out_1_1_i, out_1_2_r, out_1_2_i,
    input  out_2_1_r, out_2_1_i, out_2_2_r, out_2_2_i
  );
endinterface

// File: rtl/fft4_in_loader.sv
// fft4_in_loader
//   Input framing stage for the 4-point radix-2 FFT core. Serial complex
//   samples are collected into one of two ping-pong frame buffers. A full
//   buffer is presented to the core in butterfly order:
//     out_1_1 = x0, out_1_2 = x2, out_2_1 = x1, out_2_2 = x3.
//   Ports:
//   - clk : rising-edge clock.
//   - rst : synchronous, active-high reset.
//   - io  : fft4_in_loader_if.slave, carrying the sample stream, the frame
//           outputs and err_sync.
module fft4_in_loader #(
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fft4_in_loader_if.slave      io
);

  logic [DATA_W-1:0] buf_r [2][4];
  logic [DATA_W-1:0] buf_i [2][4];
  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_sel;
  logic              rd_sel;
  logic [1:0]        widx;
  logic              err_q;

  logic              accept;
  logic              resync;
  logic              frame_done;
  logic              consume;
  logic [1:0]        slot;

  // Ready comes from registered state only, so a consume that frees a buffer
  // opens the input on the following cycle, never in the same one.
  assign io.s_ready = ~full[wr_sel] & ~rst;
  assign io.m_valid = full[rd_sel];
  assign io.err_sync = err_q;

  assign accept     = io.s_valid & io.s_ready;
  // s_first in the middle of a frame restarts the frame at slot 0.
  assign resync     = accept & io.s_first & (widx != 2'd0);
  assign frame_done = accept & ~resync & (widx == 2'd3);
  assign consume    = io.m_valid & io.m_ready;
  assign slot       = resync ? 2'd0 : widx;

  // Completion always targets an empty buffer and consume a full one, so
  // both can hit in the same cycle without touching the same flag.
  always_comb begin
    full_nxt = full;
    if (frame_done) full_nxt[wr_sel] = 1'b1;
    if (consume)    full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      widx   <= 2'd0;
      err_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 4; k++) begin
          buf_r[b][k] <= '0;
          buf_i[b][k] <= '0;
        end
      end
    end else begin
      full  <= full_nxt;
      err_q <= resync;
      if (accept) begin
        buf_r[wr_sel][slot] <= io.s_r;
        buf_i[wr_sel][slot] <= io.s_i;
        if (resync) begin
          widx <= 2'd1;
        end else if (frame_done) begin
          widx   <= 2'd0;
          wr_sel <= ~wr_sel;
        end else begin
          widx <= widx + 2'd1;
        end
      end
      if (consume) rd_sel <= ~rd_sel;
    end
  end

  // Butterfly pairs (x0,x2) and (x1,x3) land on the core's pair ports.
  assign io.out_1_1_r = buf_r[rd_sel][0];
  assign io.out_1_1_i = buf_i[rd_sel][0];
  assign io.out_1_2_r = buf_r[rd_sel][2];
  assign io.out_1_2_i = buf_i[rd_sel][2];
  assign io.out_2_1_r = buf_r[rd_sel][1];
  assign io.out_2_1_i = buf_i[rd_sel][1];
  assign io.out_2_2_r = buf_r[rd_sel][3];
  assign io.out_2_2_i = buf_i[rd_sel][3];

endmodule

// File: tb/tb_fft4_in_loader.sv
// tb_fft4_in_loader
//   Directed bench for fft4_in_loader. Inputs change 1 time unit after the
//   rising edge, and outputs are checked in that same window, well before
//   the next edge.
module tb_fft4_in_loader;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fft4_in_loader_if #(.DATA_W(W)) bus ();

  fft4_in_loader #(.DATA_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected frame from samples in arrival order x0..x3, each sent as
  // (x, -x). The core pair ports take (x0,x2) and (x1,x3).
  task automatic chk_frame(input string tag, input logic [W-1:0] x0, input logic [W-1:0] x1,
                           input logic [W-1:0] x2, input logic [W-1:0] x3);
    chk({tag, " out_1_1_r"}, bus.out_1_1_r, x0);
    chk({tag, " out_1_1_i"}, bus.out_1_1_i, -x0);
    chk({tag, " out_1_2_r"}, bus.out_1_2_r, x2);
    chk({tag, " out_1_2_i"}, bus.out_1_2_i, -x2);
    chk({tag, " out_2_1_r"}, bus.out_2_1_r, x1);
    chk({tag, " out_2_1_i"}, bus.out_2_1_i, -x1);
    chk({tag, " out_2_2_r"}, bus.out_2_2_r, x3);
    chk({tag, " out_2_2_i"}, bus.out_2_2_i, -x3);
  endtask

  // Drive one sample (x, -x) for one cycle; the caller ensures s_ready.
  task automatic send(input logic [W-1:0] x, input logic first);
    bus.s_valid = 1'b1;
    bus.s_first = first;
    bus.s_r     = x;
    bus.s_i     = -x;
    step();
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    int           acc;
    checks = 0;
    errors = 0;
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_first = 1'b0;
    bus.s_r     = '0;
    bus.s_i     = '0;
    bus.m_ready = 1'b0;

    // ---- reset ----
    step();
    step();
    chk("rst m_valid", bus.m_valid, 0);
    chk("rst s_ready", bus.s_ready, 0);
    chk("rst err_sync", bus.err_sync, 0);
    chk_frame("rst", 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("post-rst s_ready", bus.s_ready, 1);

    // ---- basic frame ----
    bus.m_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("basic s_ready", bus.s_ready, 1);
      send(W'(k), 1'b0);
    end
    chk("basic m_valid", bus.m_valid, 1);
    chk("basic s_ready after", bus.s_ready, 1);
    chk_frame("basic", 1, 2, 3, 4);
    step();
    chk("basic consumed", bus.m_valid, 0);

    // ---- back-pressure ----
    bus.m_ready = 1'b0;
    v   = 1;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      bus.s_valid = 1'b1;
      bus.s_first = 1'b0;
      bus.s_r     = v;
      bus.s_i     = -v;
      #1;
      if (bus.s_ready) begin
        acc++;
        v++;
      end
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    chk("bp accepted", W'(acc), 8);
    chk("bp s_ready low", bus.s_ready, 0);
    chk("bp m_valid", bus.m_valid, 1);
    chk_frame("bp hold0", 1, 2, 3, 4);
    step();
    step();
    chk_frame("bp hold1", 1, 2, 3, 4);
    bus.m_ready = 1'b1;
    #1;
    chk("bp no same-cycle ready", bus.s_ready, 0);
    step();
    bus.m_ready = 1'b0;
    chk("bp frame2 valid", bus.m_valid, 1);
    chk_frame("bp frame2", 5, 6, 7, 8);
    chk("bp s_ready back", bus.s_ready, 1);
    bus.m_ready = 1'b1;
    step();
    chk("bp drained", bus.m_valid, 0);

    // ---- continuous stream of 16 ----
    bus.m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk("stream s_ready", bus.s_ready, 1);
      send(W'(k + 200), 1'b0);
      chk("stream m_valid", bus.m_valid, ((k % 4) == 3) ? 1'b1 : 1'b0);
      if ((k % 4) == 3)
        chk_frame("stream", W'(k + 197), W'(k + 198), W'(k + 199), W'(k + 200));
    end
    step();
    chk("stream idle", bus.m_valid, 0);

    // ---- resync ----
    bus.m_ready = 1'b0;
    send(10, 1'b1);
    chk("resync err 10", bus.err_sync, 0);
    send(11, 1'b0);
    chk("resync err 11", bus.err_sync, 0);
    send(20, 1'b1);
    chk("resync err pulse", bus.err_sync, 1);
    send(21, 1'b0);
    chk("resync err clear", bus.err_sync, 0);
    send(22, 1'b0);
    chk("resync no frame yet", bus.m_valid, 0);
    send(23, 1'b0);
    chk("resync m_valid", bus.m_valid, 1);
    chk("resync err quiet", bus.err_sync, 0);
    chk_frame("resync", 20, 21, 22, 23);
    bus.m_ready = 1'b1;
    step();
    chk("resync consumed", bus.m_valid, 0);

    // ---- reset mid-operation ----
    bus.m_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send(W'(k), 1'b0);
    chk("mid held", bus.m_valid, 1);
    rst = 1'b1;
    step();
    chk("mid rst m_valid", bus.m_valid, 0);
    chk("mid rst s_ready", bus.s_ready, 0);
    chk_frame("mid rst", 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mid post-rst s_ready", bus.s_ready, 1);
    for (int k = 0; k < 3; k++) send(W'(100 + k), 1'b0);
    chk("mid no stale frame", bus.m_valid, 0);
    send(103, 1'b0);
    chk("mid m_valid", bus.m_valid, 1);
    chk_frame("mid", 100, 101, 102, 103);
    bus.m_ready = 1'b1;
    step();
    chk("mid consumed", bus.m_valid, 0);

    // ---- simultaneous frame complete and consume ----
    bus.m_ready = 1'b0;
    for (int k = 0; k < 7; k++) send(W'(30 + k), 1'b0);
    bus.m_ready = 1'b1;
    send(37, 1'b0);
    bus.m_ready = 1'b0;
    chk("sim m_valid", bus.m_valid, 1);
    chk("sim s_ready", bus.s_ready, 1);
    chk_frame("sim", 34, 35, 36, 37);
    bus.m_ready = 1'b1;
    step();
    chk("sim drained", bus.m_valid, 0);

    // ---- full-width values ----
    bus.m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.s_valid = 1'b1;
      bus.s_first = 1'b0;
      bus.s_r     = 16'h7fff;
      bus.s_i     = 16'h8000;
      step();
    end
    bus.s_valid = 1'b0;
    chk("fw m_valid", bus.m_valid, 1);
    chk("fw out_1_1_r", bus.out_1_1_r, 16'h7fff);
    chk("fw out_1_1_i", bus.out_1_1_i, 16'h8000);
    chk("fw out_1_2_r", bus.out_1_2_r, 16'h7fff);
    chk("fw out_1_2_i", bus.out_1_2_i, 16'h8000);
    chk("fw out_2_1_r", bus.out_2_1_r, 16'h7fff);
    chk("fw out_2_1_i", bus.out_2_1_i, 16'h8000);
    chk("fw out_2_2_r", bus.out_2_2_r, 16'h7fff);
    chk("fw out_2_2_i", bus.out_2_2_i, 16'h8000);
    bus.m_ready = 1'b1;
    step();
    chk("fw consumed", bus.m_valid, 0);

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
